svi_line_arbiter: RTL
=====================

# svi_line_arbiter

Round-robin arbiter and turnaround sequencer for a single shared interface line. Up to `N_REQ` requesters contend for the line. The arbiter grants one owner at a time and bounds each tenure to `HOLD_MAX` cycles. Between owners it drives an override window in which the line is released to high-Z, so the consumer of the interface instance can apply and lift its force on the line without contention.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥2.
- `HOLD_MAX`, default 8: maximum consecutive cycles one owner holds the line; must be ≥1.
- `TURN_CYCLES`, default 1: length of the override (high-Z) window between owners; must be ≥1.
- `i_clk`  input  1  clock; all logic on rising edge.
- `i_rst`  input  1  reset; synchronous, active-high.
- `i_req`  input  N_REQ  per-requester request level; held high while the line is wanted.
- `i_data`  input  N_REQ  per-requester data bit to place on the line.
- `o_gnt`  output  N_REQ  one-hot grant, registered; all-zero when no owner.
- `o_owner`  output  $clog2(N_REQ)  index of current/last owner, registered.
- `o_override`  output  1  registered; 1 means the line must be released (high-Z / forced), 0 means the owner drives it.
- `o_line_data`  output  1  equals `i_data[o_owner]` when `o_override`=0, else 0 (combinational mux from registered state).
- `o_preempt`  output  1  one-cycle pulse on the first TURN cycle when a tenure ended by `HOLD_MAX` expiry.

## Operation
- States: IDLE, OWN, TURN.
- IDLE
  - `o_override`=1, `o_gnt`=0.
  - If any `i_req` is set, pick the first set bit searching from `last+1` mod `N_REQ` upward with wrap. Next cycle is OWN, with `o_gnt` one-hot at that index, `o_owner` set to it, `hold_cnt`=0.
- OWN
  - `o_override`=0, `o_gnt` held, `hold_cnt` increments each cycle.
  - Go to TURN at the end of the cycle if `!i_req[o_owner]` or `hold_cnt==HOLD_MAX-1`; otherwise stay.
  - On exit, `last` becomes `o_owner`.
- TURN
  - `o_override`=1, `o_gnt`=0, `turn_cnt` counts 0..`TURN_CYCLES`-1.
  - On the last TURN cycle, arbitrate exactly as IDLE does: any request goes directly to OWN, none goes to IDLE.
- Simultaneous owner request drop and `HOLD_MAX` expiry: go to TURN with `o_preempt`=0 (the drop takes precedence).
- The previous owner re-requesting is lowest priority at the next arbitration. With a sole requester it is re-granted after `TURN_CYCLES`, with `o_preempt` pulsing every tenure.
- Requests that change during OWN do not affect the current tenure.
- Reset:
  - Takes effect at the next edge, from any state including mid-OWN or mid-TURN.
  - State becomes IDLE; `o_gnt`=0, `o_override`=1, `o_owner`=0, `o_preempt`=0.
  - `last`=`N_REQ`-1, so the first search starts at index 0.
  - `hold_cnt` and `turn_cnt` are cleared.

## Timing
- Grant latency: request sampled in IDLE (or on the last TURN cycle) at cycle n gives `o_gnt` at n+1.
- Release latency: owner request low at cycle n gives `o_gnt`=0 and `o_override`=1 at n+1. The grant therefore persists one cycle past the request drop.
- Maximum tenure is `HOLD_MAX` cycles; the gap between tenures is exactly `TURN_CYCLES` cycles.
- `o_override` never falls on the same edge that `o_gnt` changes owner. There is always at least one cycle with `o_override`=1 and `o_gnt`=0 between two owners.
- `hold_cnt` width is $clog2(HOLD_MAX)+1 and it never wraps. `turn_cnt` width is $clog2(TURN_CYCLES)+1.

## Structure
- Package `svi_arb_pkg` holds:
  - the state enum (IDLE, OWN, TURN);
  - the reset-value localparams;
  - a parameter-check convention: elaboration-time assertions on `N_REQ`≥2, `HOLD_MAX`≥1, `TURN_CYCLES`≥1.
- Sub-module `svi_rr_pick`: combinational round-robin picker.
  - Inputs: request vector and start index.
  - Outputs: `found` and index.
  - Instantiated once; shared by IDLE and TURN arbitration.

## Test plan
Parameters for all scenarios: `N_REQ`=4, `HOLD_MAX`=4, `TURN_CYCLES`=1.
- Reset held 2 cycles with `i_req`=4'b1111 -> during reset `o_gnt`=0, `o_override`=1, `o_owner`=0, `o_preempt`=0; first grant after release is 4'b0001.
- `i_req`=4'b0100 at cycles n and n+1, low at n+2, `i_data[2]`=1 -> `o_gnt`=4'b0100 and `o_line_data`=1 at n+1 and n+2; at n+3 `o_override`=1 and `o_line_data`=0; at n+4 state IDLE.
- `i_req`=4'b0001 held continuously -> `o_gnt`=4'b0001 for 4 cycles, then 1 cycle with `o_gnt`=0 and `o_preempt`=1, repeating indefinitely.
- `i_req`=4'b1111 held from IDLE -> grants 0001, 0010, 0100, 1000, 0001, each 4 cycles long, separated by single override cycles.
- Owner drops `i_req` in its 4th OWN cycle -> TURN entered with `o_preempt`=0.
- `i_rst` pulsed for 1 cycle during the 2nd OWN cycle of owner 2 with `i_req`=4'b1111 -> next cycle `o_gnt`=0 and `o_override`=1; the following grant is 4'b0001.

Source files
------------

// File: rtl/svi_arb_pkg.sv
// rtl/svi_arb_pkg.sv - shared types, reset values and parameter check for the line arbiter
package svi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } arb_state_t;

    localparam arb_state_t RST_STATE    = ST_IDLE;
    localparam logic       RST_OVERRIDE = 1'b1;
    localparam logic       RST_PREEMPT  = 1'b0;

    function automatic bit params_ok(input int n_req, input int hold_max, input int turn_cycles);
        return (n_req >= 2) && (hold_max >= 1) && (turn_cycles >= 1);
    endfunction

endpackage

// File: rtl/svi_line_arbiter_pick.sv
// rtl/svi_line_arbiter_pick.sv - combinational round-robin picker, first set request at or after i_start
module svi_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_start,
    output logic                     o_found,
    output logic [$clog2(N_REQ)-1:0] o_idx
);

    localparam int OW = $clog2(N_REQ);

    logic [OW-1:0] w_pos;

    // Scan from the farthest candidate back to i_start so the nearest hit is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_pos = OW'((int'(i_start) + k) % N_REQ);
            if (i_req[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/svi_line_arbiter.sv
// rtl/svi_line_arbiter.sv - round-robin owner arbiter with bounded tenure and high-Z turnaround window
module svi_line_arbiter
    import svi_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_MAX    = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ-1:0]         i_data,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_owner,
    output logic                     o_override,
    output logic                     o_line_data,
    output logic                     o_preempt
);

    localparam int OW = $clog2(N_REQ);
    localparam int HW = $clog2(HOLD_MAX) + 1;
    localparam int TW = $clog2(TURN_CYCLES) + 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [OW-1:0] LAST_RST  = OW'(N_REQ - 1);

    if (!params_ok(N_REQ, HOLD_MAX, TURN_CYCLES)) begin : g_bad_params
        $error("svi_line_arbiter: illegal N_REQ/HOLD_MAX/TURN_CYCLES");
    end

    arb_state_t       r_state, w_state_nx;
    logic [N_REQ-1:0] r_gnt, w_gnt_nx;
    logic [OW-1:0]    r_owner, w_owner_nx;
    logic [OW-1:0]    r_last, w_last_nx;
    logic [HW-1:0]    r_hold_cnt, w_hold_nx;
    logic [TW-1:0]    r_turn_cnt, w_turn_nx;
    logic             r_override, w_override_nx;
    logic             r_preempt, w_preempt_nx;

    logic [OW-1:0]    w_start;
    logic             w_found;
    logic [OW-1:0]    w_idx;

    // Search begins just past the previous owner, making it lowest priority.
    assign w_start = (r_last == LAST_RST) ? '0 : r_last + OW'(1);

    svi_rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .i_req  (i_req),
        .i_start(w_start),
        .o_found(w_found),
        .o_idx  (w_idx)
    );

    always_comb begin
        w_state_nx    = r_state;
        w_gnt_nx      = r_gnt;
        w_owner_nx    = r_owner;
        w_last_nx     = r_last;
        w_hold_nx     = r_hold_cnt;
        w_turn_nx     = r_turn_cnt;
        w_override_nx = r_override;
        w_preempt_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nx    = ST_OWN;
                    w_gnt_nx      = N_REQ'(1) << w_idx;
                    w_owner_nx    = w_idx;
                    w_hold_nx     = '0;
                    w_override_nx = 1'b0;
                end
            end
            ST_OWN: begin
                w_hold_nx = r_hold_cnt + HW'(1);
                if (!i_req[r_owner] || (r_hold_cnt == HOLD_LAST)) begin
                    w_state_nx    = ST_TURN;
                    w_gnt_nx      = '0;
                    w_override_nx = 1'b1;
                    w_last_nx     = r_owner;
                    w_turn_nx     = '0;
                    // A request drop wins over simultaneous expiry, so only flag a still-wanted line.
                    w_preempt_nx  = i_req[r_owner];
                end
            end
            ST_TURN: begin
                if (r_turn_cnt == TURN_LAST) begin
                    if (w_found) begin
                        w_state_nx    = ST_OWN;
                        w_gnt_nx      = N_REQ'(1) << w_idx;
                        w_owner_nx    = w_idx;
                        w_hold_nx     = '0;
                        w_override_nx = 1'b0;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_turn_nx = r_turn_cnt + TW'(1);
                end
            end
            default: begin
                w_state_nx    = ST_IDLE;
                w_gnt_nx      = '0;
                w_override_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= RST_STATE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_last     <= LAST_RST;
            r_hold_cnt <= '0;
            r_turn_cnt <= '0;
            r_override <= RST_OVERRIDE;
            r_preempt  <= RST_PREEMPT;
        end else begin
            r_state    <= w_state_nx;
            r_gnt      <= w_gnt_nx;
            r_owner    <= w_owner_nx;
            r_last     <= w_last_nx;
            r_hold_cnt <= w_hold_nx;
            r_turn_cnt <= w_turn_nx;
            r_override <= w_override_nx;
            r_preempt  <= w_preempt_nx;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_owner     = r_owner;
    assign o_override  = r_override;
    assign o_preempt   = r_preempt;
    assign o_line_data = r_override ? 1'b0 : i_data[r_owner];

endmodule
